// File: rtl/multiword_adder_seq_if.sv
// ---------------------------------------------------------------------------
// multiword_adder_seq_if
//   Operand/result bus of the sequential multi-word adder.
//
//   Handshake: a transfer happens on a rising clock edge where both valid and
//   ready of that channel are 1. A source holds valid (and its payload) until
//   that edge; a sink may raise or drop ready at any time and ready never
//   depends combinationally on valid.
//
//   Operand channel (master -> slave): valid_i, A_i, B_i, Cin_i
//                                      [sub_i with MULTIWORD_ADDER_SUB_EN]
//                   (slave -> master): ready_o
//   Result channel  (slave -> master): valid_o, Sum_o, Cout_o
//                   (master -> slave): ready_i
//   Debug           (slave -> master): state_dbg (FSM state register)
//
//   Optional macro: MULTIWORD_ADDER_SUB_EN adds the sub_i operand bit.
// ---------------------------------------------------------------------------
interface multiword_adder_seq_if #(
  parameter int WORDS = 4
);
  localparam int W = 16 * WORDS;

  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] A_i;
  logic [W-1:0] B_i;
  logic         Cin_i;
`ifdef MULTIWORD_ADDER_SUB_EN
  logic         sub_i;
`endif
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] Sum_o;
  logic         Cout_o;
  logic [1:0]   state_dbg;

  modport master (
    output valid_i, A_i, B_i, Cin_i,
`ifdef MULTIWORD_ADDER_SUB_EN
    output sub_i,
`endif
    output ready_i,
    input  ready_o, valid_o, Sum_o, Cout_o, state_dbg
  );

  modport slave (
    input  valid_i, A_i, B_i, Cin_i,
`ifdef MULTIWORD_ADDER_SUB_EN
    input  sub_i,
`endif
    input  ready_i,
    output ready_o, valid_o, Sum_o, Cout_o, state_dbg
  );
endinterface

// File: rtl/multiword_adder_seq.sv
// ---------------------------------------------------------------------------
// multiword_adder_seq
//   Sequential wide adder: adds two WORDS x 16-bit operands one 16-bit slice
//   per clock, least-significant slice first, chaining the registered carry.
//
//   Ports:
//     clk_i   - clock, rising edge
//     rst_ni  - asynchronous active-low reset
//     bus     - multiword_adder_seq_if.slave (operand in, result out,
//               FSM state on bus.state_dbg)
//
//   FSM: IDLE (ready_o=1) -> RUN (WORDS cycles) -> DONE (valid_o=1) -> IDLE.
//   Sum_o carries partial slices while in RUN; it is meaningful only while
//   valid_o=1.
//
//   Optional macro: MULTIWORD_ADDER_SUB_EN adds bus.sub_i; when set at
//   capture the block computes A-B (B inverted, initial carry 1, Cin_i
//   ignored) and Cout_o=1 means no borrow.
// ---------------------------------------------------------------------------
module multiword_adder_seq #(
  parameter int WORDS = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  multiword_adder_seq_if.slave bus
);
  localparam int W  = 16 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, b_q, sum_q;
  logic [IW-1:0] idx_q;
  logic          carry_q;
  logic          cout_q;
  logic          cin_eff;
  logic [15:0]   a_slice, b_slice;
  logic [16:0]   slice_sum;
`ifdef MULTIWORD_ADDER_SUB_EN
  logic          sub_q;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.valid_i)         state_d = RUN;
      RUN:     if (idx_q == LAST_IDX)   state_d = DONE;
      DONE:    if (bus.ready_i)         state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // Slice adder. {idx_q, 4'd0} is 16*idx without a multiplier.
  always_comb begin
    a_slice = a_q[{idx_q, 4'd0} +: 16];
    b_slice = b_q[{idx_q, 4'd0} +: 16];
`ifdef MULTIWORD_ADDER_SUB_EN
    if (sub_q) b_slice = ~b_slice;
    cin_eff = bus.sub_i ? 1'b1 : bus.Cin_i;
`else
    cin_eff = bus.Cin_i;
`endif
    slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {16'd0, carry_q};
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef MULTIWORD_ADDER_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.valid_i) begin
            a_q     <= bus.A_i;
            b_q     <= bus.B_i;
            idx_q   <= '0;
            carry_q <= cin_eff;
            cout_q  <= 1'b0;
`ifdef MULTIWORD_ADDER_SUB_EN
            sub_q   <= bus.sub_i;
`endif
          end
        end
        RUN: begin
          sum_q[{idx_q, 4'd0} +: 16] <= slice_sum[15:0];
          carry_q                    <= slice_sum[16];
          if (idx_q == LAST_IDX) cout_q <= slice_sum[16];
          else                   idx_q  <= idx_q + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_o   = (state_q == IDLE);
  assign bus.valid_o   = (state_q == DONE);
  assign bus.Sum_o     = sum_q;
  assign bus.Cout_o    = cout_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_multiword_adder_seq.sv
module tb_multiword_adder_seq;
  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  multiword_adder_seq_if #(.WORDS(WORDS)) bus ();

  multiword_adder_seq #(.WORDS(WORDS)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [W:0] exp_q[$];   // {cout, sum}
  int         lat_q[$];   // accept edge number
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         rand_ready = 1'b0;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain wide arithmetic
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic sub);
    logic [W:0] r;
    if (sub) begin
      r[W-1:0] = a - b;
      r[W]     = (a >= b);
    end else begin
      r = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
    end
    return r;
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
    int k;
    bus.valid_i = 1'b1;
    bus.A_i     = a;
    bus.B_i     = b;
    bus.Cin_i   = cin;
`ifdef MULTIWORD_ADDER_SUB_EN
    bus.sub_i   = sub;
`endif
    for (k = 0; k < 200 && !bus.ready_o; k++) @(negedge clk);
    if (!bus.ready_o) begin
      check("accept_timeout", 0, 1);
      bus.valid_i = 1'b0;
      return;
    end
`ifdef MULTIWORD_ADDER_SUB_EN
    exp_q.push_back(model(a, b, cin, sub));
`else
    exp_q.push_back(model(a, b, cin, 1'b0));
`endif
    lat_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
    // Operands may change freely after acceptance
    bus.valid_i = 1'b0;
    bus.A_i     = {$urandom, $urandom};
    bus.B_i     = {$urandom, $urandom};
    bus.Cin_i   = 1'($urandom_range(0, 1));
    @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(negedge clk);
    check("drain_empty", (W+1)'(exp_q.size()), '0);
  endtask

  // ---------------- random downstream stalls ----------------
  always @(negedge clk) begin
    if (rand_ready) bus.ready_i = ($urandom_range(0, 3) != 0);
  end

  // ---------------- monitor ----------------
  bit         prev_valid = 1'b0;
  logic [W:0] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.valid_o) begin
        check("ready_low_in_done", (W+1)'(bus.ready_o), '0);
        if (!prev_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            logic [W:0] e;
            int acc;
            e   = exp_q.pop_front();
            acc = lat_q.pop_front();
            check("result", {bus.Cout_o, bus.Sum_o}, e);
            check("latency", (W+1)'(cyc - acc), (W+1)'(WORDS));
          end
          held = {bus.Cout_o, bus.Sum_o};
        end else begin
          check("stable_in_done", {bus.Cout_o, bus.Sum_o}, held);
        end
      end
      prev_valid = bus.valid_o;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] a, b;
    bus.valid_i = 1'b0;
    bus.A_i     = '0;
    bus.B_i     = '0;
    bus.Cin_i   = 1'b0;
`ifdef MULTIWORD_ADDER_SUB_EN
    bus.sub_i   = 1'b0;
`endif
    bus.ready_i = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_valid_o", (W+1)'(bus.valid_o), '0);
    check("rst_ready_o", (W+1)'(bus.ready_o), (W+1)'(1));
    check("rst_sum_cout", {bus.Cout_o, bus.Sum_o}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: single carry into slice 1, full ripple
    issue(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
    drain();

    // Backpressure: hold ready_i low in DONE while a new operand waits
    bus.ready_i = 1'b0;
    fork
      begin
        issue(64'h1111_2222_3333_4444, 64'h8888_7777_6666_5555, 1'b1, 1'b0);
        issue(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0);
      end
      begin
        for (int k = 0; k < 50 && !bus.valid_o; k++) @(negedge clk);
        repeat (5) begin
          @(negedge clk);
          check("bp_ready_o", (W+1)'(bus.ready_o), '0);
          check("bp_valid_o", (W+1)'(bus.valid_o), (W+1)'(1));
        end
        bus.ready_i = 1'b1;
      end
    join
    drain();

    // Reset mid-RUN at idx=2
    issue(64'hDEAD_BEEF_CAFE_F00D, 64'h1357_9BDF_2468_ACE0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_sum_cout", {bus.Cout_o, bus.Sum_o}, '0);
    check("midrun_rst_valid_o", (W+1)'(bus.valid_o), '0);
    check("midrun_rst_ready_o", (W+1)'(bus.ready_o), (W+1)'(1));
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0);
    drain();

`ifdef MULTIWORD_ADDER_SUB_EN
    issue(64'd5, 64'd7, 1'b0, 1'b1);
    issue(64'd7, 64'd5, 1'b1, 1'b1);
    issue(64'd9, 64'd9, 1'b0, 1'b1);
    drain();
`endif

    // Randomized traffic with downstream stalls
    rand_ready = 1'b1;
    for (int t = 0; t < 200; t++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: a = '1;
        1: b = '1;
        2: begin a = '1; b = '0; end
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end
    drain();
    rand_ready = 1'b0;
    bus.ready_i = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
